// File: rtl/zero_countdown_pkg.sv
// Shared constants for the zero_countdown block: FSM state codes and default width.
package zero_countdown_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  localparam int CNT_WIDTH = 8;

endpackage : zero_countdown_pkg

// File: rtl/zero_detect.sv
// Combinational all-zero detector: NOR-reduce of the input word.
module zero_detect #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value_i,
  output logic             zero_o
);

  assign zero_o = ~|value_i;

endmodule : zero_detect

// File: rtl/zero_countdown.sv
// Loadable down-counter with valid/ready load, hold/abort control, one-cycle done
// pulse at terminal count and optional auto-reload of the last loaded value.
module zero_countdown
  import zero_countdown_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             load_zero;
  logic             terminal;

  zero_detect #(.WIDTH(WIDTH)) u_zero_count (
    .value_i (count_q),
    .zero_o  (zero)
  );

  zero_detect #(.WIDTH(WIDTH)) u_zero_load (
    .value_i (load_value),
    .zero_o  (load_zero)
  );

  // RUN is never entered with a zero count, so ==1 is the only terminal case.
  assign terminal = (count_q == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid && !load_zero) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                                   state_d = ST_IDLE;
        else if (enable && terminal && !auto_reload) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          count_d  = load_value;
          reload_d = load_value;
          done_d   = load_zero;
        end
      end
      ST_RUN: begin
        if (abort) begin
          count_d = '0;
        end else if (enable) begin
          if (terminal) begin
            done_d  = 1'b1;
            count_d = auto_reload ? reload_q : '0;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      default: count_d = '0;
    endcase
  end

  always_comb begin
    load_ready = (state_q == ST_IDLE);
    busy       = (state_q == ST_RUN);
  end

  assign count = count_q;
  assign done  = done_q;

endmodule : zero_countdown

// File: doc/zero_countdown.md
Name: zero_countdown

Overview:
- Loadable down-counter that produces the all-zero condition which our combinational zero detector consumes.
- Accepts a start value through a valid/ready load handshake and decrements once per enabled clock.
- Raises a one-cycle `done` pulse when the count reaches zero, with optional auto-reload for periodic ticks.
- Sits between control logic and any consumer that waits for a byte-wide count to reach zero.

Parameters:
- WIDTH, 8, bit width of the load value and the count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  start value offered on load_value.
- load_ready  output  1  block can accept a load; high only in IDLE.
- load_value  input  WIDTH  start value; transferred when load_valid && load_ready.
- enable  input  1  decrement permission in RUN; low means hold.
- auto_reload  input  1  at terminal count, reload the last loaded value instead of stopping.
- abort  input  1  cancel the run: return to IDLE and clear count, no done.
- count  output  WIDTH  current registered count.
- zero  output  1  combinational, high when count == 0.
- busy  output  1  high in RUN.
- done  output  1  registered one-cycle pulse at terminal count.

Behaviour:
- Single clock domain. Reset is synchronous and active-high (`rst`, sampled on the `clk` rising edge) and overrides every other input.
- Reset values: state=IDLE, count=0, reload_reg=0, done=0. Therefore busy=0, load_ready=1, zero=1.
- States: IDLE, RUN (2-bit encoding, constants in package).
- IDLE:
  - load_ready=1. On load_valid: count<=load_value and reload_reg<=load_value.
  - If load_value != 0, go to RUN.
  - If load_value == 0, stay in IDLE and set done=1 for the next cycle. auto_reload is ignored here, so a zero load never free-runs.
- RUN:
  - load_ready=0. load_valid is ignored and the value is not latched.
  - Priority: rst > abort > enable.
  - abort: count<=0, state<=IDLE, done stays 0.
  - enable && count > 1: count<=count-1.
  - enable && count == 1 (terminal): done<=1.
    - If auto_reload, count<=reload_reg and state stays RUN, so count never shows 0 in this mode.
    - Otherwise count<=0 and state<=IDLE.
  - enable=0: count and state hold.
- done: a register that defaults to 0 every cycle, so it is never high for two consecutive cycles unless a reload value of 1 is used with enable held high. That case gives a continuous done every cycle, and this is the required behaviour.
- Latency: after a load of N (N ≥ 1) with enable held high, done is high during the cycle following the Nth enabled edge after the load edge. Total = N+1 edges from the handshake edge.
- Width rules:
  - Decrement is modulo 2^WIDTH. Underflow cannot occur because RUN is never entered with count=0.
  - A maximum load of 2^WIDTH−1 must count fully.
- Reset mid-run: the next edge forces the reset values. No done pulse is generated.
- Load and abort in the same IDLE cycle: the load is taken (abort has no effect in IDLE).
- Terminal and abort in the same cycle: abort wins, so there is no done.

Decomposition:
- Package zero_countdown_pkg holds:
  - state constants ST_IDLE=2'd0 and ST_RUN=2'd1;
  - default width constant CNT_WIDTH=8.
- Sub-module zero_detect(WIDTH) computes the `zero` output as the NOR-reduce of count.
  - Instantiated once.
  - Also used internally for the load_value==0 check via a second instance.

Test Plan:
- Reset: assert rst 2 cycles mid-run with count=8'd37. Required after release: count=0, zero=1, busy=0, load_ready=1, done=0, and no pulse.
- Basic run: load 8'd3 with enable=1 and auto_reload=0. Required: count 3,2,1,0; done high exactly one cycle, coincident with count=0; busy falls the same cycle; load_ready returns to 1.
- Zero load: load 8'd0 with auto_reload=1. Required: state stays IDLE, done pulses once the next cycle, no further pulses over 10 cycles.
- Hold and abort: load 8'd5, then enable toggling 1,0,0,1. Required: count 5,4,4,4,3. Then abort=1 together with enable=1 at count=1. Required: count=0, IDLE, done never asserted.
- Auto-reload: load 8'd4 with auto_reload=1 and enable=1 for 12 cycles. Required: count sequence 4,3,2,1,4,3,2,1,4…; done every 4th cycle (3 pulses); zero never high. Assertion of load_valid=1 with load_value 8'd9 during RUN is ignored.
- Maximum: load 8'hFF with enable=1. Required: done exactly 255 enabled cycles after load, and count never wraps.
